// File: rtl/avalon_pio_in_edge.sv
// avalon_pio_in_edge: Avalon-MM input PIO slave with synchroniser, per-bit edge capture
// and a maskable registered interrupt.
// Register map: 0 data (RO), 1 reserved (RO 0), 2 irqmask (RW), 3 edgecapture (W1C).
// Optional macro PIO_IN_DEBOUNCE_EN adds a per-bit debounce filter between the
// synchroniser and the stable data register.
module avalon_pio_in_edge #(
   parameter int WIDTH        = 6,
   parameter int SYNC_STAGES  = 2,
   parameter int EDGE_TYPE    = 0,
   parameter int IRQ_MODE     = 1,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
   // an input already high at reset release must also clear the debounce filter
   localparam int PRIME_CYC = SYNC_STAGES + 1 + DEBOUNCE_CYC;
`else
   localparam int PRIME_CYC = SYNC_STAGES + 1;
`endif
   localparam int PRIME_W = $clog2(PRIME_CYC + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [PRIME_W-1:0] prime_q, prime_d;
   logic [31:0] readdata_q, readdata_d;
   logic irq_q, irq_d;

   logic primed;
   logic wr_en;
   logic [WIDTH-1:0] rise, fall, edge_det, clr, irq_src;
   logic unused_wd;

   // upper writedata bits are don't-care for narrow buses
   assign unused_wd = &{1'b0, writedata};

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign primed   = (prime_q == PRIME_W'(PRIME_CYC));
   assign wr_en    = chipselect & ~write_n;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] stable_q, stable_d;

   // per-bit debounce: flip stable bit only after DEBOUNCE_CYC consecutive differing samples
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_out[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
            stable_d[i] = sync_out[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // debounce state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign data = stable_q;
`else
   assign data = sync_out;
`endif

   // next-state for synchroniser, edge detect, registers and read mux
   always_comb begin
      sync_d[0] = in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];

      prev_d  = data;
      prime_d = primed ? prime_q : prime_q + PRIME_W'(1);

      rise = data & ~prev_q;
      fall = ~data & prev_q;
      if (EDGE_TYPE == 0)      edge_det = rise;
      else if (EDGE_TYPE == 1) edge_det = fall;
      else                     edge_det = rise | fall;
      // until the pipeline has filled, prev vs data differences are reset artefacts
      if (!primed) edge_det = '0;

      mask_d = mask_q;
      clr    = '0;
      if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
      if (wr_en && address == 2'd3) clr    = writedata[WIDTH-1:0];
      // a new edge in the clearing cycle keeps the flag set
      edgecap_d = (edgecap_q & ~clr) | edge_det;

      irq_src = (IRQ_MODE == 0) ? data : edgecap_q;
      irq_d   = |(irq_src & mask_q);

      case (address)
         2'd0:    readdata_d = 32'(data);
         2'd2:    readdata_d = 32'(mask_q);
         2'd3:    readdata_d = 32'(edgecap_q);
         default: readdata_d = '0;
      endcase
   end

   // state registers, all cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         prev_q     <= '0;
         prime_q    <= '0;
         mask_q     <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         prime_q    <= prime_d;
         mask_q     <= mask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
